regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the RISC-V core; successor to the single-write/2-read file.

---
 rtl/regfile_mp.sv | 175 +++++++++++++++++
 tb/tb_regfile_mp.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file for the RISC-V core.
// Two prioritised write ports, NUM_RD combinational read ports with
// write-to-read bypass, a pending-write scoreboard, and a dump sequencer
// that streams every register to the trace/printer logic.
module regfile_mp #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 32,
  parameter int               NUM_RD   = 2,
  parameter int               SP_INDEX = 2,
  parameter logic [XLEN-1:0]  SP_RESET = 32'h000EFFFF,
  localparam int              AW       = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  // read ports
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  // write port 0 (main writeback)
  input  logic                   wr0_en,
  input  logic [AW-1:0]          wr0_addr,
  input  logic [XLEN-1:0]        wr0_data,
  // write port 1 (link/secondary writeback, higher priority)
  input  logic                   wr1_en,
  input  logic [AW-1:0]          wr1_addr,
  input  logic [XLEN-1:0]        wr1_data,
  // scoreboard
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_rd,
  output logic [DEPTH-1:0]       busy_vec,
  // dump sequencer
  input  logic                   dump_start,
  output logic                   dump_valid,
  output logic [AW-1:0]          dump_idx,
  output logic [XLEN-1:0]        dump_data,
  output logic                   dump_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dump_state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [XLEN-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  // A write "hits" only when enabled and not aimed at x0, which is hardwired to zero.
  logic wr0_hit;
  logic wr1_hit;

  assign wr0_hit = wr0_en && (wr0_addr != '0);
  assign wr1_hit = wr1_en && (wr1_addr != '0);

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------

  // Commit writes on the rising edge; port 1 is applied last so it wins a tie.
  // NOTE: the array is reset because the stack pointer must hold SP_RESET out of
  // reset and the other registers must read 0; this forces flops, not a RAM macro.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
    end else begin
      // NOTE: non-blocking assignments here, so the later port-1 assignment
      // overrides port 0 without any ordering hazard against the readers.
      if (wr0_hit) regs[wr0_addr] <= wr0_data;
      if (wr1_hit) regs[wr1_addr] <= wr1_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports with bypass: port-1 data beats port-0 data beats the array.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit0;
    logic          hit1;

    assign addr = rd_addr[k*AW +: AW];
    assign hit1 = wr1_hit && (wr1_addr == addr);
    assign hit0 = wr0_hit && (wr0_addr == addr);

    assign rd_data[k*XLEN +: XLEN] = (addr == '0) ? '0       :
                                     hit1         ? wr1_data :
                                     hit0         ? wr0_data :
                                                    regs[addr];

    // A write landing this cycle retires the pending bit, so report not-busy now.
    assign rd_busy[k] = busy[addr] && !hit0 && !hit1;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------

  // Next scoreboard: writes clear, then issue sets (set wins on a collision).
  // NOTE: busy_next gets a full default before the conditional updates, so no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (wr0_hit) busy_next[wr0_addr] = 1'b0;
    if (wr1_hit) busy_next[wr1_addr] = 1'b0;
    if (issue_en && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_next;
  end

  assign busy_vec = busy;

  // ---------------------------------------------------------------------------
  // Dump sequencer: IDLE -> RUN (DEPTH beats) -> DONE (one cycle) -> IDLE
  // ---------------------------------------------------------------------------
  dump_state_t state;
  dump_state_t state_next;

  logic            valid_d;
  logic            done_d;
  logic [AW-1:0]   idx_d;
  logic [XLEN-1:0] data_d;

  // Dump state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic; dump_start is only honoured in IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (dump_start) state_next = RUN;
      RUN:     if (dump_idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: values the dump outputs take after the coming edge.
  // dump_idx doubles as the beat counter; data is the registered array value.
  always_comb begin
    valid_d = (state_next == RUN);
    done_d  = (state_next == DONE);
    idx_d   = '0;
    if (state_next == RUN) begin
      idx_d = (state == RUN) ? dump_idx + AW'(1) : '0;
    end
    data_d  = valid_d ? regs[idx_d] : '0;
  end

  // Dump output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
      dump_done  <= 1'b0;
    end else begin
      dump_valid <= valid_d;
      dump_idx   <= idx_d;
      dump_data  <= data_d;
      dump_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against a
// behavioural model (array of register values plus a pending-bit array).
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;
  localparam logic [31:0] SP_RESET = 32'h000EFFFF;

  logic                   clock;
  logic                   reset_n;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   wr0_en;
  logic [AW-1:0]          wr0_addr;
  logic [XLEN-1:0]        wr0_data;
  logic                   wr1_en;
  logic [AW-1:0]          wr1_addr;
  logic [XLEN-1:0]        wr1_data;
  logic                   issue_en;
  logic [AW-1:0]          issue_rd;
  logic [DEPTH-1:0]       busy_vec;
  logic                   dump_start;
  logic                   dump_valid;
  logic [AW-1:0]          dump_idx;
  logic [XLEN-1:0]        dump_data;
  logic                   dump_done;

  regfile_mp #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .SP_INDEX(2), .SP_RESET(SP_RESET)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .busy_vec(busy_vec),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_idx(dump_idx),
    .dump_data(dump_data), .dump_done(dump_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: architectural register values and pending bits.
  logic [31:0] model_regs [DEPTH];
  bit          model_busy [DEPTH];

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      model_regs[i] = (i == 2) ? SP_RESET : 32'h0;
      model_busy[i] = 1'b0;
    end
  endtask

  // What a read of address a returns this cycle, given the inputs being driven.
  function automatic logic [31:0] exp_read(input int a);
    if (a == 0) return 32'h0;
    if (wr1_en && int'(wr1_addr) == a) return wr1_data;
    if (wr0_en && int'(wr0_addr) == a) return wr0_data;
    return model_regs[a];
  endfunction

  function automatic logic exp_rd_busy(input int a);
    if (a == 0) return 1'b0;
    if (wr1_en && int'(wr1_addr) == a) return 1'b0;
    if (wr0_en && int'(wr0_addr) == a) return 1'b0;
    return model_busy[a];
  endfunction

  function automatic logic [DEPTH-1:0] exp_busy_vec();
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = model_busy[i];
    return v;
  endfunction

  // Compare every read port, its busy bit and the whole scoreboard.
  task automatic check_ports(input string tag);
    for (int k = 0; k < NUM_RD; k++) begin
      int a;
      a = int'(rd_addr[k*AW +: AW]);
      check($sformatf("%s rd_data[%0d] x%0d", tag, k, a), 64'(rd_data[k*XLEN +: XLEN]), 64'(exp_read(a)));
      check($sformatf("%s rd_busy[%0d] x%0d", tag, k, a), 64'(rd_busy[k]), 64'(exp_rd_busy(a)));
    end
    check({tag, " busy_vec"}, 64'(busy_vec), 64'(exp_busy_vec()));
  endtask

  // Apply the architectural effect of the driven inputs, then take the edge.
  task automatic tick();
    if (wr0_en && wr0_addr != 0) begin
      model_regs[wr0_addr] = wr0_data;
      model_busy[wr0_addr] = 1'b0;
    end
    if (wr1_en && wr1_addr != 0) begin
      model_regs[wr1_addr] = wr1_data;
      model_busy[wr1_addr] = 1'b0;
    end
    if (issue_en && issue_rd != 0) model_busy[issue_rd] = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wr0_en = 0; wr0_addr = 0; wr0_data = 0;
    wr1_en = 0; wr1_addr = 0; wr1_data = 0;
    issue_en = 0; issue_rd = 0; dump_start = 0;
  endtask

  task automatic set_rd(input int p0, input int p1);
    rd_addr[0*AW +: AW] = AW'(p0);
    rd_addr[1*AW +: AW] = AW'(p1);
  endtask

  initial begin
    reset_n = 1'b1;
    rd_addr = '0;
    idle_inputs();
    model_reset();

    // 1: reset dropped mid-cycle
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    set_rd(0, 2);
    #1;
    check_ports("reset");
    check("reset dump_valid", 64'(dump_valid), 64'(0));
    check("reset dump_done", 64'(dump_done), 64'(0));
    check("reset dump_idx", 64'(dump_idx), 64'(0));
    check("reset rd x2", 64'(rd_data[1*XLEN +: XLEN]), 64'(SP_RESET));
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      set_rd(i, 0);
      #1;
      check($sformatf("reset reg x%0d", i), 64'(rd_data[0 +: XLEN]), 64'((i == 2) ? SP_RESET : 32'h0));
    end
    tick();

    // 2: write/read same cycle via bypass, then from the array
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    set_rd(5, 0);
    #1;
    check("bypass x5", 64'(rd_data[0 +: XLEN]), 64'(32'hDEADBEEF));
    check_ports("bypass");
    tick();
    idle_inputs();
    #1;
    check("stored x5", 64'(rd_data[0 +: XLEN]), 64'(32'hDEADBEEF));

    // 3: port 1 wins a same-address collision; x0 ignores writes
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h1;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h2;
    set_rd(7, 7);
    #1;
    check("collide bypass x7", 64'(rd_data[0 +: XLEN]), 64'(32'h2));
    tick();
    idle_inputs();
    #1;
    check("collide x7", 64'(rd_data[1*XLEN +: XLEN]), 64'(32'h2));
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF;
    set_rd(0, 0);
    #1;
    check("x0 bypass", 64'(rd_data[0 +: XLEN]), 64'(0));
    tick();
    idle_inputs();
    #1;
    check("x0 after write", 64'(rd_data[0 +: XLEN]), 64'(0));

    // 4: scoreboard set / set-wins / clear
    issue_en = 1; issue_rd = 9;
    set_rd(9, 0);
    tick();
    idle_inputs();
    #1;
    check("issue busy[9]", 64'(busy_vec[9]), 64'(1));
    check("issue rd_busy", 64'(rd_busy[0]), 64'(1));
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h99; issue_en = 1; issue_rd = 9;
    #1;
    check_ports("set+clear");
    tick();
    idle_inputs();
    #1;
    check("set wins busy[9]", 64'(busy_vec[9]), 64'(1));
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h9A;
    #1;
    check("clear visible rd_busy", 64'(rd_busy[0]), 64'(0));
    tick();
    idle_inputs();
    #1;
    check("clear busy[9]", 64'(busy_vec[9]), 64'(0));
    issue_en = 1; issue_rd = 0;
    tick();
    idle_inputs();
    #1;
    check("busy[0] never set", 64'(busy_vec[0]), 64'(0));

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      wr0_en   = 1'($urandom_range(0, 1));
      wr0_addr = AW'($urandom);
      wr0_data = $urandom;
      wr1_en   = 1'($urandom_range(0, 3) == 0);
      wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom);
      wr1_data = $urandom;
      issue_en = 1'($urandom_range(0, 1));
      issue_rd = ($urandom_range(0, 4) == 0) ? wr0_addr : AW'($urandom);
      set_rd(($urandom_range(0, 3) == 0) ? int'(wr0_addr) : int'($urandom_range(0, DEPTH-1)),
             ($urandom_range(0, 3) == 0) ? int'(wr1_addr) : int'($urandom_range(0, DEPTH-1)));
      #1;
      check_ports($sformatf("rand%0d", n));
      tick();
    end
    idle_inputs();

    // 5: preset reg[i] = 3*i then dump all registers
    for (int i = 1; i < DEPTH; i += 2) begin
      wr0_en = 1; wr0_addr = AW'(i); wr0_data = 32'(i * 3);
      wr1_en = (i + 1 < DEPTH); wr1_addr = AW'(i + 1); wr1_data = 32'(3 * (i + 1));
      tick();
    end
    idle_inputs();
    #1;
    check("pre-dump valid", 64'(dump_valid), 64'(0));
    dump_start = 1;
    tick();
    dump_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("dump%0d valid", i), 64'(dump_valid), 64'(1));
      check($sformatf("dump%0d idx", i), 64'(dump_idx), 64'(i));
      check($sformatf("dump%0d data", i), 64'(dump_data), 64'(i * 3));
      check($sformatf("dump%0d done", i), 64'(dump_done), 64'(0));
      if (i == 4) dump_start = 1;  // must be ignored while running
      tick();
      dump_start = 0;
    end
    check("dump end valid", 64'(dump_valid), 64'(0));
    check("dump end done", 64'(dump_done), 64'(1));
    tick();
    check("dump after done", 64'(dump_done), 64'(0));
    check("dump after valid", 64'(dump_valid), 64'(0));

    // 6: reset at beat 10 aborts the dump
    dump_start = 1;
    tick();
    dump_start = 0;
    for (int i = 0; i < 10; i++) tick();
    check("beat10 idx", 64'(dump_idx), 64'(10));
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("abort valid", 64'(dump_valid), 64'(0));
    check("abort idx", 64'(dump_idx), 64'(0));
    check("abort data", 64'(dump_data), 64'(0));
    @(posedge clock);
    #1 reset_n = 1'b1;
    set_rd(2, 5);
    for (int i = 0; i < DEPTH + 4; i++) begin
      #1;
      check($sformatf("post-abort done c%0d", i), 64'(dump_done), 64'(0));
      check($sformatf("post-abort valid c%0d", i), 64'(dump_valid), 64'(0));
      tick();
    end
    check_ports("post-abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
